// File: rtl/register_block_pkg.sv
// -----------------------------------------------------------------------------
// register_block_pkg
//   Shared constants for the processor's general-purpose register file.
//   DATA_W   : width of each register and of the read/write data ports
//   ADDR_W   : width of the register index ports
//   NUM_REGS : number of architectural registers (2**ADDR_W)
//   REG_ZERO : index of the hardwired-zero register
// -----------------------------------------------------------------------------
package register_block_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage : register_block_pkg

// File: rtl/register_block.sv
// -----------------------------------------------------------------------------
// register_block
//   32 x 32-bit general-purpose register file for the decode/writeback stages.
//   Two combinational read ports, one synchronous write port, register 0
//   hardwired to zero. No read-during-write bypass: a read of the register
//   being written returns the old value until the clock edge. Forwarding is
//   left to the pipeline.
//
// Ports
//   Read_d1  out DATA_W  contents of register Read_r1 (combinational)
//   Read_d2  out DATA_W  contents of register Read_r2 (combinational)
//   Data     in  DATA_W  write data
//   Read_r1  in  ADDR_W  read index, port 1
//   Read_r2  in  ADDR_W  read index, port 2
//   Write_r  in  ADDR_W  write index
//   RegWrite in  1       write enable, active high
//   clk      in  1       clock; writes take effect on the rising edge
//   rst_n    in  1       asynchronous active-low reset; clears every register
//
// The storage array is named reg_s so that benches can preload or dump it
// hierarchically.
// -----------------------------------------------------------------------------
module register_block
    import register_block_pkg::*;
#(
    parameter int unsigned P_DATA_W   = DATA_W,
    parameter int unsigned P_ADDR_W   = ADDR_W,
    parameter int unsigned P_NUM_REGS = NUM_REGS
) (
    output logic [P_DATA_W-1:0] Read_d1,
    output logic [P_DATA_W-1:0] Read_d2,
    input  logic [P_DATA_W-1:0] Data,
    input  logic [P_ADDR_W-1:0] Read_r1,
    input  logic [P_ADDR_W-1:0] Read_r2,
    input  logic [P_ADDR_W-1:0] Write_r,
    input  logic                RegWrite,
    input  logic                clk,
    input  logic                rst_n
);

    localparam logic [P_ADDR_W-1:0] ZERO_IDX = P_ADDR_W'(REG_ZERO);

    logic [P_DATA_W-1:0] reg_s [0:P_NUM_REGS-1];

    logic write_en;

    // A write to the zero register is dropped here, so reg_s[0] never leaves
    // its reset value.
    assign write_en = RegWrite && (Write_r != ZERO_IDX);

    // NOTE: the whole array is cleared by the asynchronous reset because the
    // architecture requires every register to read zero out of reset; this
    // forces flops rather than a RAM macro, which is acceptable at 32 entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(P_NUM_REGS); i++) begin
                reg_s[i] <= '0;
            end
        end else if (write_en) begin
            reg_s[Write_r] <= Data;
        end
    end

    // Read muxes mask index 0 explicitly, so the zero register reads zero
    // even if the storage entry were ever disturbed (e.g. by a hierarchical
    // preload from a bench).
    assign Read_d1 = (Read_r1 == ZERO_IDX) ? '0 : reg_s[Read_r1];
    assign Read_d2 = (Read_r2 == ZERO_IDX) ? '0 : reg_s[Read_r2];

endmodule : register_block

// File: tb/tb_register_block.sv
// -----------------------------------------------------------------------------
// tb_register_block
//   Directed bench for register_block. The stimulus process pushes expected
//   values into a scoreboard queue; a separate monitor process pops each
//   entry and compares it against the DUT read port or storage entry.
// -----------------------------------------------------------------------------
module tb_register_block;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef enum int { K_RD1, K_RD2, K_MEM } kind_e;

    typedef struct {
        string        name;
        kind_e        kind;
        int           idx;
        logic [DW-1:0] exp;
    } sb_entry_t;

    logic [DW-1:0] Read_d1;
    logic [DW-1:0] Read_d2;
    logic [DW-1:0] Data;
    logic [AW-1:0] Read_r1;
    logic [AW-1:0] Read_r2;
    logic [AW-1:0] Write_r;
    logic          RegWrite;
    logic          clk;
    logic          rst_n;

    sb_entry_t sb_q [$];
    event      sample_ev;
    int        n_cmp = 0;
    int        n_err = 0;

    register_block dut (
        .Read_d1  (Read_d1),
        .Read_d2  (Read_d2),
        .Data     (Data),
        .Read_r1  (Read_r1),
        .Read_r2  (Read_r2),
        .Write_r  (Write_r),
        .RegWrite (RegWrite),
        .clk      (clk),
        .rst_n    (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: drains the scoreboard whenever the stimulus signals that the
    // DUT outputs have settled.
    initial begin
        sb_entry_t     e;
        logic [DW-1:0] act;
        forever begin
            @(sample_ev);
            while (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                case (e.kind)
                    K_RD1:   act = Read_d1;
                    K_RD2:   act = Read_d2;
                    default: act = dut.reg_s[e.idx];
                endcase
                n_cmp++;
                if (act !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %0h, expected %0h", e.name, act, e.exp);
                end
            end
        end
    end

    // Push one expectation and let the monitor sample it before any input moves.
    task automatic check(input string name, input kind_e kind, input int idx,
                         input logic [DW-1:0] exp);
        sb_entry_t e;
        #1;
        e.name = name;
        e.kind = kind;
        e.idx  = idx;
        e.exp  = exp;
        sb_q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    // Expect reg_s[0..14] all zero except one optional index.
    task automatic dump_check(input string name, input int hot_idx,
                              input logic [DW-1:0] hot_val);
        for (int i = 0; i < 15; i++) begin
            check($sformatf("%s_r%0d", name, i), K_MEM, i,
                  (i == hot_idx) ? hot_val : '0);
        end
    endtask

    task automatic write_edges(input logic [AW-1:0] wr, input logic [DW-1:0] d,
                               input logic we, input int edges);
        @(negedge clk);
        Write_r  = wr;
        Data     = d;
        RegWrite = we;
        repeat (edges) @(posedge clk);
        @(negedge clk);
        RegWrite = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        RegWrite = 1'b0;
        Data     = '0;
        Read_r1  = '0;
        Read_r2  = '0;
        Write_r  = '0;

        // 1. Reset state.
        repeat (2) @(negedge clk);
        Read_r1 = 5'd1;
        check("in_reset_rd1", K_RD1, 0, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        Read_r1 = 5'd0;
        Read_r2 = 5'd1;
        check("post_reset_rd1_r0", K_RD1, 0, 32'd0);
        check("post_reset_rd2_r1", K_RD2, 0, 32'd0);
        dump_check("reset_dump", -1, '0);

        // 2. RegWrite=0 leaves storage untouched.
        write_edges(5'd2, 32'd20, 1'b0, 2);
        check("we0_mem2", K_MEM, 2, 32'd0);
        Read_r1 = 5'd8;
        Read_r2 = 5'd15;
        check("we0_rd1_r8", K_RD1, 0, 32'd0);
        check("we0_rd2_r15", K_RD2, 0, 32'd0);

        // 3. Write 40 into r2; both ports on the same index.
        write_edges(5'd2, 32'd40, 1'b1, 2);
        check("wr40_mem2", K_MEM, 2, 32'd40);
        Read_r1 = 5'd2;
        Read_r2 = 5'd2;
        check("wr40_rd1", K_RD1, 0, 32'd40);
        check("wr40_rd2", K_RD2, 0, 32'd40);

        // 4. Overwrite r2 with 35; nothing else changes.
        write_edges(5'd2, 32'd35, 1'b1, 2);
        dump_check("wr35_dump", 2, 32'd35);

        // 5a. Writes to r0 are dropped.
        write_edges(5'd0, 32'd99, 1'b1, 1);
        Read_r1 = 5'd0;
        check("r0_rd1", K_RD1, 0, 32'd0);
        check("r0_mem0", K_MEM, 0, 32'd0);

        // 5b. Read-during-write: old value before the edge, new after.
        @(negedge clk);
        Read_r2  = 5'd5;
        Write_r  = 5'd5;
        Data     = 32'd7;
        RegWrite = 1'b1;
        check("rdw_before_edge", K_RD2, 0, 32'd0);
        @(posedge clk);
        check("rdw_after_edge", K_RD2, 0, 32'd7);
        @(negedge clk);
        RegWrite = 1'b0;
        Read_r1  = 5'd5;
        Read_r2  = 5'd2;
        check("two_port_rd1_r5", K_RD1, 0, 32'd7);
        check("two_port_rd2_r2", K_RD2, 0, 32'd35);

        // 6. Asynchronous reset mid-cycle dominates a pending write.
        write_edges(5'd3, 32'd11, 1'b1, 1);
        Read_r1 = 5'd3;
        check("r3_written", K_RD1, 0, 32'd11);
        @(negedge clk);
        Write_r  = 5'd3;
        Data     = 32'd55;
        RegWrite = 1'b1;
        #2;
        rst_n = 1'b0;
        check("async_rst_rd1_r3", K_RD1, 0, 32'd0);
        @(posedge clk);
        check("rst_dominates_write", K_RD1, 0, 32'd0);
        check("rst_clears_mem2", K_MEM, 2, 32'd0);
        @(negedge clk);
        RegWrite = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        check("after_rst_rd1_r3", K_RD1, 0, 32'd0);

        // Drain with a bounded wait.
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) #1;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_register_block
